// File: rtl/sme_pkg.sv
// Shared types and constants for the string-match engine front-end scheduler.
package sme_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STR,
    S_ARB,
    S_PAT,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  // Special characters understood by the match engine.
  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] STAR   = 8'h2a;
  localparam logic [7:0] CARET  = 8'h5e;
  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] DOT    = 8'h2e;

  // Engine limits and default watchdog length.
  localparam int PAT_MAX_DEF = 8;
  localparam int STR_MAX_DEF = 32;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr_i,
// wrapping around. Purely combinational; the caller owns the pointer.
module rr_arbiter
  import sme_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] id_o,
  output logic                    any_o
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/sme_query_sched.sv
// Front-end scheduler for the single-engine string-match core: loads one host
// string, then time-shares the engine among pattern requesters round-robin,
// returning each tagged result (or a watchdog error) to its owner.
module sme_query_sched
  import sme_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      str_valid,
  input  logic [7:0]                str_char,
  input  logic                      str_last,
  output logic                      str_ready,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*8*PAT_MAX-1:0] pat_data,
  input  logic [NREQ*4-1:0]         pat_len,
  output logic [NREQ-1:0]           gnt,
  output logic                      eng_isstring,
  output logic                      eng_ispattern,
  output logic [7:0]                eng_chardata,
  input  logic                      eng_valid,
  input  logic                      eng_match,
  input  logic [4:0]                eng_index,
  output logic                      resp_valid,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic                      resp_match,
  output logic [4:0]                resp_index,
  output logic                      resp_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = 8 * PAT_MAX;
  localparam int LW  = $clog2(PAT_MAX + 1);
  localparam int SW  = $clog2(STR_MAX + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic           str_loaded_q, str_loaded_d;
  logic [SW-1:0]  str_cnt_q, str_cnt_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [PW-1:0]  pat_q, pat_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  k_q, k_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           isstring_q, isstring_d;
  logic           ispattern_q, ispattern_d;
  logic [7:0]     chardata_q, chardata_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic           resp_match_q, resp_match_d;
  logic [4:0]     resp_index_q, resp_index_d;
  logic           resp_err_q, resp_err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_id;
  logic            arb_any;
  logic [PW-1:0]   arb_pat;
  logic [LW-1:0]   arb_len;
  logic [7:0]      pat_char;

  // Zero-length requests still send one char; over-long ones are cut to the engine limit.
  function automatic logic [LW-1:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0) return LW'(1);
    if (int'(l) > PAT_MAX) return LW'(PAT_MAX);
    return LW'(l);
  endfunction

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .id_o  (arb_id),
    .any_o (arb_any)
  );

  assign arb_pat  = pat_data[int'(arb_id)*PW +: PW];
  assign arb_len  = clamp_len(pat_len[int'(arb_id)*4 +: 4]);
  assign pat_char = pat_q[int'(k_q)*8 +: 8];

  assign str_ready     = (state_q == S_IDLE) || (state_q == S_STR);
  assign gnt           = (state_q == S_ARB) ? arb_gnt : '0;
  assign eng_isstring  = isstring_q;
  assign eng_ispattern = ispattern_q;
  assign eng_chardata  = chardata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_match    = resp_match_q;
  assign resp_index    = resp_index_q;
  assign resp_err      = resp_err_q;

  // Next-state and registered-output logic for the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    str_loaded_d = str_loaded_q;
    str_cnt_d    = str_cnt_q;
    rr_d         = rr_q;
    id_d         = id_q;
    pat_d        = pat_q;
    len_d        = len_q;
    k_d          = k_q;
    timer_d      = timer_q;
    isstring_d   = 1'b0;
    ispattern_d  = 1'b0;
    chardata_d   = 8'h00;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_match_d = resp_match_q;
    resp_index_d = resp_index_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        // A waiting string char wins over patterns so they match the new string.
        if (str_valid) begin
          str_loaded_d = str_last;
          str_cnt_d    = SW'(1);
          isstring_d   = 1'b1;
          chardata_d   = str_char;
          state_d      = str_last ? S_GAP : S_STR;
        end else if (str_loaded_q && arb_any) begin
          state_d = S_ARB;
        end
      end
      S_STR: begin
        if (str_valid) begin
          // Chars beyond the engine limit are taken but not forwarded.
          if (str_cnt_q < SW'(STR_MAX)) begin
            isstring_d = 1'b1;
            chardata_d = str_char;
            str_cnt_d  = str_cnt_q + 1'b1;
          end
          if (str_last) begin
            str_loaded_d = 1'b1;
            state_d      = S_GAP;
          end
        end
      end
      S_ARB: begin
        if (arb_any) begin
          id_d        = arb_id;
          pat_d       = arb_pat;
          len_d       = arb_len;
          k_d         = LW'(1);
          rr_d        = (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
          ispattern_d = 1'b1;
          chardata_d  = arb_pat[7:0];
          state_d     = S_PAT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PAT: begin
        if (k_q < len_q) begin
          ispattern_d = 1'b1;
          chardata_d  = pat_char;
          k_d         = k_q + 1'b1;
        end else begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_valid) begin
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_match_d = eng_match;
          resp_index_d = eng_index;
          resp_err_d   = 1'b0;
          state_d      = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_match_d = 1'b0;
          resp_index_d = 5'd0;
          resp_err_d   = 1'b1;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        resp_id_d    = '0;
        resp_match_d = 1'b0;
        resp_index_d = 5'd0;
        resp_err_d   = 1'b0;
        state_d      = S_GAP;
      end
      S_GAP: begin
        // One quiet cycle lets the engine recover before the next job.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial job or string.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      str_loaded_q <= 1'b0;
      str_cnt_q    <= '0;
      rr_q         <= '0;
      id_q         <= '0;
      pat_q        <= '0;
      len_q        <= '0;
      k_q          <= '0;
      timer_q      <= '0;
      isstring_q   <= 1'b0;
      ispattern_q  <= 1'b0;
      chardata_q   <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_match_q <= 1'b0;
      resp_index_q <= 5'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      str_loaded_q <= str_loaded_d;
      str_cnt_q    <= str_cnt_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      k_q          <= k_d;
      timer_q      <= timer_d;
      isstring_q   <= isstring_d;
      ispattern_q  <= ispattern_d;
      chardata_q   <= chardata_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_match_q <= resp_match_d;
      resp_index_q <= resp_index_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_sme_query_sched.sv
// Directed bench for sme_query_sched: a table of pattern jobs plus hand-written
// sequences for string loading, priority, watchdog and mid-job reset.
module tb_sme_query_sched;
  import sme_pkg::*;

  localparam int TMO  = 64;
  localparam int SMAX = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        str_valid;
  logic [7:0]  str_char;
  logic        str_last;
  logic        str_ready;
  logic [3:0]  req;
  logic [255:0] pat_data;
  logic [15:0] pat_len;
  logic [3:0]  gnt;
  logic        eng_isstring;
  logic        eng_ispattern;
  logic [7:0]  eng_chardata;
  logic        eng_valid;
  logic        eng_match;
  logic [4:0]  eng_index;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic        resp_match;
  logic [4:0]  resp_index;
  logic        resp_err;

  logic [23:0] outs;
  assign outs = {eng_isstring, eng_ispattern, eng_chardata, gnt, resp_valid,
                 resp_id, resp_match, resp_index, resp_err};

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] rq;
    int         id;
    logic [3:0] plen;
    int         elen;
    logic       m;
    logic [4:0] ix;
    int         dly;
  } vec_t;

  vec_t tbl[10];

  sme_query_sched #(.NREQ(4), .PAT_MAX(8), .STR_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .str_valid     (str_valid),
    .str_char      (str_char),
    .str_last      (str_last),
    .str_ready     (str_ready),
    .req           (req),
    .pat_data      (pat_data),
    .pat_len       (pat_len),
    .gnt           (gnt),
    .eng_isstring  (eng_isstring),
    .eng_ispattern (eng_ispattern),
    .eng_chardata  (eng_chardata),
    .eng_valid     (eng_valid),
    .eng_match     (eng_match),
    .eng_index     (eng_index),
    .resp_valid    (resp_valid),
    .resp_id       (resp_id),
    .resp_match    (resp_match),
    .resp_index    (resp_index),
    .resp_err      (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pchar(input int i, input int k);
    if (i == 2 && k == 0) return "c";
    if (i == 2 && k == 1) return "d";
    if (i == 3 && k == 0) return CARET;
    if (i == 3 && k == 1) return DOT;
    if (i == 3 && k == 2) return STAR;
    if (i == 3 && k == 3) return DOLLAR;
    return 8'h41 + 8'(8 * i + k);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    str_valid = 1'b0;
    str_last = 1'b0;
    eng_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Feed a string char by char; each accepted char must appear on the engine
  // port the following cycle unless it is past the engine limit.
  task automatic load_string(input string s, output int waits);
    waits = 0;
    for (int i = 0; i < s.len(); i++) begin
      str_valid = 1'b1;
      str_char  = s[i];
      str_last  = (i == s.len() - 1);
      while (!str_ready && waits < 20) begin
        tick();
        waits++;
      end
      tick();
      if (i < SMAX) check("str_char", 32'({eng_isstring, eng_chardata}), 32'({1'b1, s[i]}));
      else          check("str_drop", 32'(eng_isstring), 32'd0);
    end
    str_valid = 1'b0;
    str_last  = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    int cnt = 0;
    while (gnt == 4'd0 && cnt < 40) begin
      tick();
      cnt++;
    end
    ok = (gnt != 4'd0);
    if (!ok) check("gnt_timeout", 32'(gnt), 32'd1);
  endtask

  // One full pattern job: grant, pattern stream, engine answer (dly<0: none), response.
  task automatic run_pattern(input int id, input int elen, input logic m,
                             input logic [4:0] ix, input int dly);
    bit ok;
    int cnt;
    wait_gnt(ok);
    if (!ok) return;
    check("gnt", 32'(gnt), 32'(4'b0001 << id));
    tick();
    for (int k = 0; k < elen; k++) begin
      check("pat_char", 32'({eng_ispattern, eng_chardata}), 32'({1'b1, pchar(id, k)}));
      tick();
    end
    check("pat_end", 32'(eng_ispattern), 32'd0);
    if (dly >= 0) begin
      repeat (dly) tick();
      eng_valid = 1'b1;
      eng_match = m;
      eng_index = ix;
      tick();
      eng_valid = 1'b0;
      check("resp", 32'({resp_valid, resp_id, resp_match, resp_index, resp_err}),
            32'({1'b1, 2'(id), m, ix, 1'b0}));
    end else begin
      eng_match = 1'b1;
      eng_index = 5'd7;
      cnt = 0;
      while (!resp_valid && cnt < 200) begin
        tick();
        cnt++;
      end
      check("tmo_cycles", 32'(cnt), 32'(TMO));
      check("tmo_resp", 32'({resp_valid, resp_id, resp_match, resp_index, resp_err}),
            32'({1'b1, 2'(id), 1'b0, 5'd0, 1'b1}));
    end
    tick();
    check("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int w;
    int g;
    int r;
    bit ok;
    reset = 1'b1;
    str_valid = 1'b0;
    str_char = 8'h00;
    str_last = 1'b0;
    req = 4'b0000;
    eng_valid = 1'b0;
    eng_match = 1'b0;
    eng_index = 5'd0;
    pat_len = {4'd2, 4'd2, 4'd2, 4'd2};
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++)
        pat_data[i*64 + k*8 +: 8] = pchar(i, k);

    tbl[0] = '{4'b1111, 0, 4'd3,  3, 1'b0, 5'd0,  0};
    tbl[1] = '{4'b1111, 1, 4'd1,  1, 1'b1, 5'd5,  3};
    tbl[2] = '{4'b1111, 2, 4'd8,  8, 1'b1, 5'd31, 1};
    tbl[3] = '{4'b1111, 3, 4'd4,  4, 1'b0, 5'd0,  5};
    tbl[4] = '{4'b1111, 0, 4'd4,  4, 1'b1, 5'd7,  0};
    tbl[5] = '{4'b0001, 0, 4'd0,  1, 1'b1, 5'd1,  2};
    tbl[6] = '{4'b0001, 0, 4'd12, 8, 1'b0, 5'd0,  0};
    tbl[7] = '{4'b1010, 1, 4'd15, 8, 1'b1, 5'd12, 4};
    tbl[8] = '{4'b1010, 3, 4'd5,  5, 1'b1, 5'd2,  1};
    tbl[9] = '{4'b1010, 1, 4'd2,  2, 1'b0, 5'd0,  2};

    // Reset state
    do_reset();
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_ready", 32'(str_ready), 32'd1);

    // Requests without a loaded string, and a stray engine strobe, do nothing
    req = 4'b1111;
    eng_valid = 1'b1;
    eng_match = 1'b1;
    eng_index = 5'd9;
    tick();
    eng_valid = 1'b0;
    g = 0;
    r = 0;
    repeat (6) begin
      if (gnt != 4'd0) g++;
      if (resp_valid) r++;
      tick();
    end
    check("nostr_gnt", 32'(g), 32'd0);
    check("stray_resp", 32'(r), 32'd0);
    req = 4'b0000;

    // "ab cd" then requester 2 with pattern "cd"
    do_reset();
    load_string({"ab", SPACE, "cd"}, w);
    req = 4'b0100;
    pat_len[8 +: 4] = 4'd2;
    tick();
    check("str_end", 32'(eng_isstring), 32'd0);
    run_pattern(2, 2, 1'b1, 5'd3, 2);
    req = 4'b0000;

    // Table: round-robin order, length clamping, mixed request masks
    do_reset();
    load_string("x^y.z*$", w);
    for (int v = 0; v < 10; v++) begin
      req = tbl[v].rq;
      pat_len[tbl[v].id*4 +: 4] = tbl[v].plen;
      run_pattern(tbl[v].id, tbl[v].elen, tbl[v].m, tbl[v].ix, tbl[v].dly);
    end
    req = 4'b0000;

    // Engine never answers: watchdog error response
    req = 4'b0100;
    pat_len[8 +: 4] = 4'd3;
    run_pattern(2, 3, 1'b0, 5'd0, -1);

    // String and request together: string goes first
    req = 4'b0010;
    pat_len[4 +: 4] = 4'd1;
    load_string("pq", w);
    check("prio_wait", 32'(w), 32'd1);
    run_pattern(1, 1, 1'b1, 5'd2, 1);

    // Reset in the middle of a pattern
    req = 4'b0001;
    pat_len[0 +: 4] = 4'd8;
    wait_gnt(ok);
    tick();
    tick();
    check("pat_pre_rst", 32'(eng_ispattern), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async", 32'(outs), 32'd0);
    tick();
    check("rst_hold", 32'(outs), 32'd0);
    reset = 1'b0;
    g = 0;
    repeat (8) begin
      tick();
      if (gnt != 4'd0) g++;
    end
    check("rst_nostr", 32'(g), 32'd0);

    // Over-long string: only the first SMAX chars reach the engine
    load_string("0123456789abcdefghijklmnopqrstuvWX", w);
    run_pattern(0, 8, 1'b0, 5'd0, 0);
    req = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
